// File: rtl/aes_pkg.sv
// Shared AES round-datapath types and GF(2^8) helpers.
// Imported by the iterative MixColumns unit and its column slice.
package aes_pkg;

    localparam logic [7:0] GF_POLY  = 8'h1B;
    localparam int         NUM_COLS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_mixcolumns_iter_if.sv
// Start/done column bus between a round controller
// and the iterative MixColumns unit.
interface aes_mixcolumns_iter_if;

    logic        start_in;
    logic        inv_in;
    logic [31:0] state0;
    logic [31:0] state1;
    logic [31:0] state2;
    logic [31:0] state3;
    logic [31:0] state_out0;
    logic [31:0] state_out1;
    logic [31:0] state_out2;
    logic [31:0] state_out3;
    logic        done;
    logic        busy;

    modport master (
        output start_in, inv_in,
        output state0, state1, state2, state3,
        input  state_out0, state_out1, state_out2, state_out3,
        input  done, busy
    );

    modport slave (
        input  start_in, inv_in,
        input  state0, state1, state2, state3,
        output state_out0, state_out1, state_out2, state_out3,
        output done, busy
    );

endinterface

// File: rtl/aes_mixcol_column.sv
// One-column (Inv)MixColumns, purely combinational.
// Byte j of col/res is row j of the column.
module aes_mixcol_column
    import aes_pkg::*;
#(
    parameter bit INVERSE_EN = 1'b1
) (
    input  logic [31:0] col,
    input  logic        inv,
    output logic [31:0] res
);

    logic [31:0] m2;
    logic [31:0] m3;
    logic [31:0] fw;

    for (genvar j = 0; j < 4; j++) begin : g_fwd_row
        localparam int J1 = (j + 1) % 4;
        localparam int J2 = (j + 2) % 4;
        localparam int J3 = (j + 3) % 4;
        assign m2[8*j+:8] = xtime(col[8*j+:8]);
        assign m3[8*j+:8] = m2[8*j+:8] ^ col[8*j+:8];
        assign fw[8*j+:8] = m2[8*j+:8] ^ m3[8*J1+:8]
                          ^ col[8*J2+:8] ^ col[8*J3+:8];
    end

    if (INVERSE_EN) begin : g_inv
        logic [31:0] m4, m8, m9, mb, md, me, iv;
        // 9/B/D/E multiples are sums of the x2/x4/x8 chain
        assign m9 = m8 ^ col;
        assign mb = m8 ^ m2 ^ col;
        assign md = m8 ^ m4 ^ col;
        assign me = m8 ^ m4 ^ m2;
        for (genvar j = 0; j < 4; j++) begin : g_inv_row
            localparam int J1 = (j + 1) % 4;
            localparam int J2 = (j + 2) % 4;
            localparam int J3 = (j + 3) % 4;
            assign m4[8*j+:8] = xtime(m2[8*j+:8]);
            assign m8[8*j+:8] = xtime(m4[8*j+:8]);
            assign iv[8*j+:8] = me[8*j+:8] ^ mb[8*J1+:8]
                              ^ md[8*J2+:8] ^ m9[8*J3+:8];
        end
        assign res = inv ? iv : fw;
    end else begin : g_fwd_only
        logic unused_inv;
        assign unused_inv = inv;
        assign res        = fw;
    end

endmodule

// File: rtl/aes_mixcolumns_iter.sv
// Iterative AES (Inv)MixColumns: COLS_PER_CYCLE columns per clock,
// start/done handshake over aes_mixcolumns_iter_if.
module aes_mixcolumns_iter
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit INVERSE_EN     = 1'b1
) (
    input logic                 clk,
    input logic                 reset,
    aes_mixcolumns_iter_if.slave bus
);

    localparam int C  = COLS_PER_CYCLE;
    localparam int N  = NUM_COLS / C;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (!(C == 1 || C == 2 || C == 4)) begin : g_bad_cols
        $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end

    fsm_t                      st;
    logic [CW-1:0]             cnt;
    logic [NUM_COLS-1:0][31:0] cap_q;
    logic [NUM_COLS-1:0][31:0] out_q;
    logic                      mode_q;
    logic                      done_q;
    logic                      busy_q;

    logic [C-1:0][1:0]  sel;
    logic [C-1:0][31:0] col_in;
    logic [C-1:0][31:0] col_res;

    for (genvar j = 0; j < C; j++) begin : g_lane
        assign sel[j]    = 2'(32'(cnt) * C + j);
        assign col_in[j] = cap_q[sel[j]];
        aes_mixcol_column #(
            .INVERSE_EN (INVERSE_EN)
        ) u_col (
            .col (col_in[j]),
            .inv (mode_q),
            .res (col_res[j])
        );
    end

    // DONE behaves like IDLE for start sampling, giving N+1 cycle back-to-back ops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st     <= ST_IDLE;
            cnt    <= '0;
            cap_q  <= '0;
            out_q  <= '0;
            mode_q <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            unique case (st)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (bus.start_in) begin
                        cap_q  <= {bus.state3, bus.state2,
                                   bus.state1, bus.state0};
                        mode_q <= bus.inv_in & INVERSE_EN;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        st     <= ST_RUN;
                    end else begin
                        busy_q <= 1'b0;
                        st     <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    for (int j = 0; j < C; j++) begin
                        out_q[sel[j]] <= col_res[j];
                    end
                    if (cnt == CW'(N - 1)) begin
                        cnt    <= '0;
                        done_q <= 1'b1;
                        st     <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    assign bus.state_out0 = out_q[0];
    assign bus.state_out1 = out_q[1];
    assign bus.state_out2 = out_q[2];
    assign bus.state_out3 = out_q[3];
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_aes_mixcolumns_iter.sv
// Bench for aes_mixcolumns_iter: C=1/2/4 and a forward-only build
// run side by side against a GF(2^8) matrix-product model.
module tb_aes_mixcolumns_iter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             start;
    logic             inv;
    logic [3:0][31:0] st_v;

    int n_vec = 0;
    int n_err = 0;
    int lat[4] = '{4, 2, 1, 4};

    aes_mixcolumns_iter_if if_c1 ();
    aes_mixcolumns_iter_if if_c2 ();
    aes_mixcolumns_iter_if if_c4 ();
    aes_mixcolumns_iter_if if_fo ();

    assign if_c1.start_in = start;
    assign if_c1.inv_in   = inv;
    assign if_c1.state0   = st_v[0];
    assign if_c1.state1   = st_v[1];
    assign if_c1.state2   = st_v[2];
    assign if_c1.state3   = st_v[3];
    assign if_c2.start_in = start;
    assign if_c2.inv_in   = inv;
    assign if_c2.state0   = st_v[0];
    assign if_c2.state1   = st_v[1];
    assign if_c2.state2   = st_v[2];
    assign if_c2.state3   = st_v[3];
    assign if_c4.start_in = start;
    assign if_c4.inv_in   = inv;
    assign if_c4.state0   = st_v[0];
    assign if_c4.state1   = st_v[1];
    assign if_c4.state2   = st_v[2];
    assign if_c4.state3   = st_v[3];
    assign if_fo.start_in = start;
    assign if_fo.inv_in   = inv;
    assign if_fo.state0   = st_v[0];
    assign if_fo.state1   = st_v[1];
    assign if_fo.state2   = st_v[2];
    assign if_fo.state3   = st_v[3];

    logic [3:0]             done_w;
    logic [3:0]             busy_w;
    logic [3:0][3:0][31:0]  out_w;

    assign done_w = {if_fo.done, if_c4.done, if_c2.done, if_c1.done};
    assign busy_w = {if_fo.busy, if_c4.busy, if_c2.busy, if_c1.busy};
    assign out_w[0] = {if_c1.state_out3, if_c1.state_out2,
                       if_c1.state_out1, if_c1.state_out0};
    assign out_w[1] = {if_c2.state_out3, if_c2.state_out2,
                       if_c2.state_out1, if_c2.state_out0};
    assign out_w[2] = {if_c4.state_out3, if_c4.state_out2,
                       if_c4.state_out1, if_c4.state_out0};
    assign out_w[3] = {if_fo.state_out3, if_fo.state_out2,
                       if_fo.state_out1, if_fo.state_out0};

    aes_mixcolumns_iter #(.COLS_PER_CYCLE(1), .INVERSE_EN(1'b1))
        dut_c1 (.clk(clk), .reset(rst_n), .bus(if_c1));
    aes_mixcolumns_iter #(.COLS_PER_CYCLE(2), .INVERSE_EN(1'b1))
        dut_c2 (.clk(clk), .reset(rst_n), .bus(if_c2));
    aes_mixcolumns_iter #(.COLS_PER_CYCLE(4), .INVERSE_EN(1'b1))
        dut_c4 (.clk(clk), .reset(rst_n), .bus(if_c4));
    aes_mixcolumns_iter #(.COLS_PER_CYCLE(1), .INVERSE_EN(1'b0))
        dut_fo (.clk(clk), .reset(rst_n), .bus(if_fo));

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // carry-less product, then long division by x^8+x^4+x^3+x+1
    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p ^= 15'(a) << i;
        for (int i = 14; i >= 8; i--)
            if (p[i]) p ^= 15'h11B << (i - 8);
        return p[7:0];
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c,
                                            input logic iv);
        logic [7:0] k[4];
        logic [7:0] r;
        logic [31:0] o;
        if (iv) k = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
        else    k = '{8'h02, 8'h03, 8'h01, 8'h01};
        o = '0;
        for (int i = 0; i < 4; i++) begin
            r = '0;
            for (int j = 0; j < 4; j++)
                r ^= gmul(k[(j - i + 4) % 4], c[8*j+:8]);
            o[8*i+:8] = r;
        end
        return o;
    endfunction

    function automatic logic [3:0][31:0] mix_state(
        input logic [3:0][31:0] s, input logic iv);
        logic [3:0][31:0] o;
        for (int i = 0; i < 4; i++) o[i] = mix_col(s[i], iv);
        return o;
    endfunction

    function automatic logic [3:0][31:0] rnd_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk_idle(input string tag);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("%s d%0d done", tag, d), 32'(done_w[d]), 32'h0);
            chk($sformatf("%s d%0d busy", tag, d), 32'(busy_w[d]), 32'h0);
            for (int c = 0; c < 4; c++)
                chk($sformatf("%s d%0d out%0d", tag, d, c),
                    out_w[d][c], 32'h0);
        end
    endtask

    // one op on all four DUTs; ex for inverse-capable, exn for forward-only
    task automatic do_op(input logic [3:0][31:0] c, input logic iv,
                         input logic [3:0][31:0] ex,
                         input logic [3:0][31:0] exn,
                         input bit scramble);
        logic [31:0] e;
        @(negedge clk);
        st_v  = c;
        inv   = iv;
        start = 1'b1;
        @(posedge clk);
        for (int m = 0; m < 6; m++) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                chk($sformatf("op d%0d done m%0d", d, m),
                    32'(done_w[d]), 32'(m == lat[d]));
                chk($sformatf("op d%0d busy m%0d", d, m),
                    32'(busy_w[d]), 32'(m <= lat[d]));
                if (m >= lat[d]) begin
                    for (int k = 0; k < 4; k++) begin
                        e = (d == 3) ? exn[k] : ex[k];
                        chk($sformatf("op d%0d out%0d m%0d", d, k, m),
                            out_w[d][k], e);
                    end
                end
            end
            if (m == 0) begin
                start = 1'b0;
                if (scramble) begin
                    st_v = rnd_state();
                    inv  = 1'($urandom);
                end
            end
        end
    endtask

    logic [3:0][31:0] t1_in, t1_out, t3_in, t3_out, t6_in, t6_out;
    logic [3:0][31:0] hv[4];
    logic [3:0][31:0] hx;
    logic [3:0][31:0] rc;
    logic             ri;

    initial begin
        start = 1'b0;
        inv   = 1'b0;
        st_v  = '0;
        t1_in  = {32'hC6C6C6C6, 32'h01010101, 32'h5C220AF2, 32'h455313DB};
        t1_out = {32'hC6C6C6C6, 32'h01010101, 32'h9D58DC9F, 32'hBCA14D8E};
        t3_in  = {32'h00000000, 32'hC6C6C6C6, 32'h01010101, 32'hF8BD7E4D};
        t3_out = {32'h00000000, 32'hC6C6C6C6, 32'h01010101, 32'h4C31262D};
        t6_in  = {32'h0, 32'h0, 32'h0, 32'hD5D4D4D4};
        t6_out = {32'h0, 32'h0, 32'h0, 32'hD6D7D5D5};

        repeat (3) @(negedge clk);
        chk_idle("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("post_rst");

        do_op(t1_in, 1'b0, t1_out, t1_out, 1'b0);
        do_op(t1_out, 1'b1, t1_in, mix_state(t1_out, 1'b0), 1'b0);
        do_op(t3_in, 1'b1, t3_out, mix_state(t3_in, 1'b0), 1'b0);
        do_op(t6_in, 1'b1, mix_state(t6_in, 1'b1), t6_out, 1'b0);

        // start held high on the C=1 unit: one op every 5 cycles
        for (int p = 0; p < 4; p++) hv[p] = rnd_state();
        @(negedge clk);
        st_v  = hv[0];
        inv   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        for (int m = 0; m < 20; m++) begin
            @(negedge clk);
            chk($sformatf("hold done m%0d", m),
                32'(done_w[0]), 32'(m % 5 == 4));
            if (m % 5 == 4) begin
                hx = mix_state(hv[m / 5], 1'b0);
                for (int k = 0; k < 4; k++)
                    chk($sformatf("hold out%0d m%0d", k, m),
                        out_w[0][k], hx[k]);
                if (m < 19) st_v = hv[m / 5 + 1];
                inv = 1'b0;
            end else if (m % 5 == 1) begin
                st_v = rnd_state();
                inv  = 1'($urandom);
            end
        end
        start = 1'b0;
        repeat (8) @(negedge clk);

        // reset during the C=1 unit's RUN cycle 2
        st_v  = rnd_state();
        inv   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_idle("abort");
        @(negedge clk);
        rst_n = 1'b1;
        for (int m = 0; m < 6; m++) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++)
                chk($sformatf("abort d%0d nodone m%0d", d, m),
                    32'(done_w[d]), 32'h0);
        end

        for (int t = 0; t < 12; t++) begin
            rc = rnd_state();
            ri = 1'($urandom);
            do_op(rc, ri, mix_state(rc, ri), mix_state(rc, 1'b0), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
